// File: rtl/fft_input_buffer.sv
// Ping-pong frame buffer feeding the FFT butterfly pipeline: one bank fills while the other drains.
// Build option: define FFT_BITREV_EN to drain each frame in bit-reversed address order (DIT feed).
module fft_input_buffer #(
   parameter int N_POINT = 16,
   parameter int LOG2N   = 4,
   parameter int DW      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_re,
   input  logic [DW-1:0]    in_im,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DW-1:0]    out_re,
   output logic [DW-1:0]    out_im,
   output logic [LOG2N-1:0] out_idx,
   output logic             out_last
);

   // Handshake: a transfer happens on a rising clk edge where valid && ready;
   // the producer holds valid and data stable until that edge.

   typedef enum logic {
      S_IDLE,
      S_DRAIN
   } rd_state_e;

   rd_state_e        state_q, state_d;
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
   logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
   logic [1:0]       bank_full_q, bank_full_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;
   logic [DW-1:0]    out_re_q, out_re_d;
   logic [DW-1:0]    out_im_q, out_im_d;
   logic [LOG2N-1:0] out_idx_q, out_idx_d;

   logic [2*DW-1:0]  mem [2][N_POINT];
   logic [LOG2N-1:0] rd_addr;
   logic             wr_accept;
   logic             rd_load;
   logic             wr_last;
   logic             rd_last;

`ifdef FFT_BITREV_EN
   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
      logic [LOG2N-1:0] r;
      for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
      return r;
   endfunction

   assign rd_addr = bitrev(rd_cnt_q);
`else
   assign rd_addr = rd_cnt_q;
`endif

   assign in_ready  = !rst_n && !bank_full_q[wr_bank_q];
   assign wr_accept = in_valid && in_ready;
   assign wr_last   = (wr_cnt_q == LOG2N'(N_POINT - 1));
   assign rd_last   = (rd_cnt_q == LOG2N'(N_POINT - 1));
   // Loading straight from IDLE keeps the fill-to-first-output latency at two cycles.
   assign rd_load   = bank_full_q[rd_bank_q] && (!out_valid_q || out_ready);

   always_comb begin
      state_d     = state_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      bank_full_d = bank_full_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_re_d    = out_re_q;
      out_im_d    = out_im_q;
      out_idx_d   = out_idx_q;

      if (wr_accept) begin
         if (wr_last) begin
            bank_full_d[wr_bank_q] = 1'b1;
            wr_bank_d              = ~wr_bank_q;
            wr_cnt_d               = '0;
         end else begin
            wr_cnt_d = wr_cnt_q + LOG2N'(1);
         end
      end

      if (rd_load) begin
         {out_re_d, out_im_d} = mem[rd_bank_q][rd_addr];
         out_idx_d   = rd_addr;
         out_valid_d = 1'b1;
         out_last_d  = rd_last;
         if (rd_last) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
            rd_cnt_d               = '0;
         end else begin
            rd_cnt_d = rd_cnt_q + LOG2N'(1);
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      case (state_q)
         S_IDLE:  if (rd_load) state_d = S_DRAIN;
         S_DRAIN: if (rd_load && rd_last && !bank_full_q[~rd_bank_q]) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q     <= S_IDLE;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         bank_full_q <= 2'b00;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_re_q    <= '0;
         out_im_q    <= '0;
         out_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         bank_full_q <= bank_full_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_re_q    <= out_re_d;
         out_im_q    <= out_im_d;
         out_idx_q   <= out_idx_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_accept) mem[wr_bank_q][wr_cnt_q] <= {in_re, in_im};
   end

   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_re    = out_re_q;
   assign out_im    = out_im_q;
   assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_fft_input_buffer.sv
// Scoreboard bench for fft_input_buffer: frames are pushed to an expected queue in drain order.
module tb_fft_input_buffer;
   localparam int N  = 16;
   localparam int LG = 4;
   localparam int DW = 16;
   localparam int EW = LG + 1 + 2 * DW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_re;
   logic [DW-1:0] in_im;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_re;
   logic [DW-1:0] out_im;
   logic [LG-1:0] out_idx;
   logic          out_last;

   always #5 clk = ~clk;

   fft_input_buffer #(.N_POINT(N), .LOG2N(LG), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_re     (in_re),
      .in_im     (in_im),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_re    (out_re),
      .out_im    (out_im),
      .out_idx   (out_idx),
      .out_last  (out_last)
   );

   int            n_tests = 0;
   int            n_fail  = 0;
   int            n_fire  = 0;
   int            n_acc   = 0;
   int            bubbles = 0;
   logic [EW-1:0] exp_q[$];
   logic [DW-1:0] fr_re[N];
   logic [DW-1:0] fr_im[N];
   int            wr_m = 0;
   bit            pending = 0;
   bit            rand_data = 0;
   int            seq = 0;
   logic [DW-1:0] nxt_re, nxt_im;
   bit            prev_stall = 0;
   logic [EW:0]   held;
   int            br16[N] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int rd_order(input int i);
`ifdef FFT_BITREV_EN
      return br16[i];
`else
      return i;
`endif
   endfunction

   task automatic push_frame();
      int a;
      for (int i = 0; i < N; i++) begin
         a = rd_order(i);
         exp_q.push_back({LG'(a), (i == N - 1), fr_re[a], fr_im[a]});
      end
   endtask

   // Called at a falling edge once inputs are set; accounts for the coming rising edge.
   task automatic tick();
      logic [EW-1:0] got, e;
      got = {out_idx, out_last, out_re, out_im};
      if (!rst_n) begin
         if (prev_stall) check("hold_stable", {out_valid, got}, held);
         if (out_valid && out_ready) begin
            n_fire++;
            if (exp_q.size() == 0) check("spurious_out", 64'd1, 64'd0);
            else begin
               e = exp_q.pop_front();
               check("out_sample", got, e);
            end
         end
         prev_stall = out_valid && !out_ready;
         held = {out_valid, got};
         if (in_valid && in_ready) begin
            pending = 0;
            n_acc++;
            fr_re[wr_m] = in_re;
            fr_im[wr_m] = in_im;
            wr_m++;
            if (wr_m == N) begin
               push_frame();
               wr_m = 0;
            end
         end
      end else begin
         prev_stall = 0;
      end
      @(negedge clk);
   endtask

   task automatic cyc(input bit offer, input bit rdy);
      if (!pending && offer) begin
         pending = 1;
         if (rand_data) begin
            nxt_re = DW'($urandom);
            nxt_im = DW'($urandom);
         end else begin
            nxt_re = DW'(seq);
            nxt_im = DW'(-seq);
         end
         seq++;
      end
      in_valid  = pending;
      in_re     = nxt_re;
      in_im     = nxt_im;
      out_ready = rdy;
      tick();
   endtask

   task automatic do_reset();
      rst_n     = 1'b1;
      pending   = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      check("in_ready_in_rst", in_ready, 0);
      tick();
      rst_n = 1'b0;
      exp_q.delete();
      wr_m = 0;
      prev_stall = 0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_data", {out_idx, out_re, out_im}, 0);
      check("rst_in_ready", in_ready, 1);
   endtask

   task automatic drain(input int mode, input int budget);
      int k;
      bit r;
      k = 0;
      while (exp_q.size() > 0 && k < budget) begin
         if (mode == 0) r = 1'b1;
         else if (mode == 2) r = (k % 2 == 0);
         else r = ($urandom_range(0, 99) < 70);
         cyc(0, r);
         k++;
      end
      check("drain_done", exp_q.size(), 0);
   endtask

   task automatic note_bubble(input int base);
      if (n_fire - base >= 17 && n_fire - base < 48 && !out_valid) bubbles++;
   endtask

   initial begin
      int base, k;
      rst_n = 1'b1;
      in_valid = 1'b0;
      in_re = '0;
      in_im = '0;
      out_ready = 1'b1;
      nxt_re = '0;
      nxt_im = '0;
      @(negedge clk);

      // Single frame, latency and order
      do_reset();
      seq = 0;
      rand_data = 0;
      for (int i = 0; i < N; i++) begin
         check("t1_in_ready", in_ready, 1);
         cyc(1, 1);
      end
      check("t1_valid_at_t1", out_valid, 0);
      cyc(0, 1);
      check("t1_valid_at_t2", out_valid, 1);
      drain(0, 100);

      // Three frames back to back
      do_reset();
      base = n_fire;
      bubbles = 0;
      for (int i = 0; i < 3 * N; i++) begin
         check("t2_in_ready", in_ready, 1);
         note_bubble(base);
         cyc(1, 1);
      end
      k = 0;
      while (exp_q.size() > 0 && k < 100) begin
         note_bubble(base);
         cyc(0, 1);
         k++;
      end
      check("t2_drain_done", exp_q.size(), 0);
      check("t2_bubbles", bubbles, 0);

      // Both banks fill under backpressure
      do_reset();
      rand_data = 1;
      for (int i = 0; i < 2 * N; i++) begin
         check("t3_in_ready", in_ready, 1);
         cyc(1, 0);
      end
      for (int i = 0; i < 4; i++) begin
         check("t3_full", in_ready, 0);
         cyc(1, 0);
      end
      base = n_fire;
      k = 0;
      while (!in_ready && k < 40) begin
         cyc(1, 1);
         k++;
      end
      check("t3_ready_back_after", n_fire - base, 15);
      drain(0, 200);

      // out_ready toggling
      do_reset();
      for (int i = 0; i < N; i++) cyc(1, (i % 2) == 0);
      drain(2, 200);

      // Reset mid-fill and mid-drain
      do_reset();
      for (int i = 0; i < 7; i++) cyc(1, 1);
      do_reset();
      for (int i = 0; i < N; i++) cyc(1, 1);
      for (int i = 0; i < 5; i++) cyc(0, 1);
      check("t5_mid_drain_valid", out_valid, 1);
      do_reset();
      for (int i = 0; i < N; i++) cyc(1, 1);
      drain(0, 100);

      // Random gaps on both sides, 100 frames
      do_reset();
      base = n_acc;
      k = 0;
      while (n_acc - base < 100 * N && k < 20000) begin
         cyc($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70);
         k++;
      end
      check("t6_accepted", n_acc - base, 100 * N);
      drain(3, 5000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
